wr_sram_mc: RTL and testbench

- Multi-channel, parametrised SRAM write engine; successor to the single-port SRAM writer.
- Accepts write requests from NUM_PORTS ingress ports and buffers one request per port.
- Grants ports round-robin, pulls bytes from the granted port's write FIFO and drives an external async SRAM with programmable WE pulse width.
- Sits between the per-port write FIFOs / queue manager and the SRAM pins.

---
 rtl/wr_sram_pkg.sv | 24 ++
 rtl/wr_sram_mc_rr_arbiter.sv | 30 +++
 rtl/wr_sram_mc.sv | 153 +++++++++++++++
 tb/tb_wr_sram_mc.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wr_sram_pkg.sv
// Shared types and que-info field helpers for the multi-port SRAM write engine.
package wr_sram_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    SETUP = 3'd2,
    WE    = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Each que_info slice is {len, start_addr}; the address occupies the low bits.
  localparam int QI_ADDR_LSB = 0;

  function automatic int qi_len_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int qi_slice_lsb(input int port, input int len_w, input int addr_w);
    return port * (len_w + addr_w);
  endfunction

endpackage

// File: rtl/wr_sram_mc_rr_arbiter.sv
// Combinational round-robin pick: first requesting port at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PW        = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PW-1:0]        ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PW-1:0]        idx,
  output logic                 valid
);

  int p;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    p     = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      p = (int'(ptr) + k) % NUM_PORTS;
      if (!valid && req[p]) begin
        valid    = 1'b1;
        idx      = PW'(p);
        grant[p] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wr_sram_mc.sv
// Multi-port SRAM write engine: one pending request per port, round-robin grant,
// FIFO bytes written to an async SRAM with a programmable WE pulse width.
module wr_sram_mc
  import wr_sram_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 8,
  parameter int LEN_W     = 11,
  parameter int WE_CYC    = 2
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst_n,
  input  logic [NUM_PORTS-1:0]             port_req_done,
  input  logic [NUM_PORTS*(LEN_W+ADDR_W)-1:0] port_que_info,
  output logic [NUM_PORTS-1:0]             wr_fifo_ren,
  input  logic [NUM_PORTS*DATA_W-1:0]      wr_fifo_data,
  output logic [NUM_PORTS-1:0]             port_wr_re,
  output logic [NUM_PORTS-1:0]             port_wr_done,
  output logic [NUM_PORTS-1:0]             port_req_ovf,
  output logic                             busy,
  output logic [ADDR_W-1:0]                sram_addr,
  output logic [DATA_W-1:0]                sram_wdata,
  output logic                             sram_cs_n,
  output logic                             sram_oe_n,
  output logic                             sram_we_n
);

  localparam int QW = LEN_W + ADDR_W;
  localparam int PW = $clog2(NUM_PORTS);

  state_t               state, state_nx;
  logic [NUM_PORTS-1:0] pend;
  logic [QW-1:0]        info_q [NUM_PORTS];
  logic [PW-1:0]        rr_ptr, gnt_idx, cur;
  logic [NUM_PORTS-1:0] gnt_oh;
  logic                 gnt_vld;
  logic                 take;
  logic [QW-1:0]        gnt_info;
  logic [ADDR_W-1:0]    gnt_addr, addr_cnt;
  logic [LEN_W-1:0]     gnt_len, rem_cnt;
  logic [3:0]           we_cnt;
  logic                 last_word;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PW(PW)) u_arb (
    .req   (pend),
    .ptr   (rr_ptr),
    .grant (gnt_oh),
    .idx   (gnt_idx),
    .valid (gnt_vld)
  );

  assign take      = (state == IDLE) && gnt_vld;
  assign gnt_info  = info_q[gnt_idx];
  assign gnt_addr  = gnt_info[QI_ADDR_LSB +: ADDR_W];
  assign gnt_len   = gnt_info[qi_len_lsb(ADDR_W) +: LEN_W];
  assign last_word = (rem_cnt == LEN_W'(1));
  assign busy      = (state != IDLE);
  assign sram_oe_n = 1'b1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    wr_fifo_ren  = '0;
    port_wr_re   = '0;
    port_wr_done = '0;
    case (state)
      IDLE: if (gnt_vld) begin
        port_wr_re = gnt_oh;
        state_nx   = (gnt_len == '0) ? DONE : RD;
      end
      RD: begin
        wr_fifo_ren[cur] = 1'b1;
        state_nx         = SETUP;
      end
      SETUP: state_nx = WE;
      WE:    if (we_cnt == '0) state_nx = HOLD;
      HOLD:  state_nx = last_word ? DONE : RD;
      DONE: begin
        port_wr_done[cur] = 1'b1;
        state_nx          = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A port being granted this cycle frees its slot, so a same-cycle request is accepted.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend         <= '0;
      port_req_ovf <= '0;
      for (int i = 0; i < NUM_PORTS; i++) info_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (port_req_done[i] && (!pend[i] || (take && gnt_oh[i]))) begin
          pend[i]   <= 1'b1;
          info_q[i] <= port_que_info[qi_slice_lsb(i, LEN_W, ADDR_W) +: QW];
        end else begin
          if (take && gnt_oh[i])          pend[i]         <= 1'b0;
          if (port_req_done[i] && pend[i]) port_req_ovf[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rr_ptr     <= '0;
      cur        <= '0;
      addr_cnt   <= '0;
      rem_cnt    <= '0;
      we_cnt     <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_cs_n  <= 1'b1;
      sram_we_n  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (take) begin
          cur      <= gnt_idx;
          addr_cnt <= gnt_addr;
          rem_cnt  <= gnt_len;
          rr_ptr   <= (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
        end
        RD: begin
          sram_addr <= addr_cnt;
          sram_cs_n <= 1'b0;
          sram_we_n <= 1'b1;
        end
        SETUP: begin
          sram_wdata <= wr_fifo_data[int'(cur)*DATA_W +: DATA_W];
          sram_we_n  <= 1'b0;
          we_cnt     <= 4'(WE_CYC - 1);
        end
        WE: begin
          if (we_cnt == '0) sram_we_n <= 1'b1;
          else              we_cnt    <= we_cnt - 1'b1;
        end
        HOLD: begin
          addr_cnt <= addr_cnt + 1'b1;
          rem_cnt  <= rem_cnt - 1'b1;
          if (last_word) sram_cs_n <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wr_sram_mc.sv
// Bench for wr_sram_mc: directed scenarios plus random multi-port traffic against a
// transaction-level model (per-port FIFO contents, expected writes, RR grant order).
module tb_wr_sram_mc;

  localparam int NUM_PORTS = 4;
  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 8;
  localparam int LEN_W     = 11;
  localparam int WE_CYC    = 2;
  localparam int QW        = LEN_W + ADDR_W;

  logic                          sys_clk = 1'b0;
  logic                          sys_rst_n = 1'b0;
  logic [NUM_PORTS-1:0]          port_req_done = '0;
  logic [NUM_PORTS*QW-1:0]       port_que_info = '0;
  logic [NUM_PORTS-1:0]          wr_fifo_ren;
  logic [NUM_PORTS*DATA_W-1:0]   wr_fifo_data = '0;
  logic [NUM_PORTS-1:0]          port_wr_re, port_wr_done, port_req_ovf;
  logic                          busy;
  logic [ADDR_W-1:0]             sram_addr;
  logic [DATA_W-1:0]             sram_wdata;
  logic                          sram_cs_n, sram_oe_n, sram_we_n;

  wr_sram_mc #(
    .NUM_PORTS(NUM_PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .WE_CYC(WE_CYC)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .port_req_done(port_req_done), .port_que_info(port_que_info),
    .wr_fifo_ren(wr_fifo_ren), .wr_fifo_data(wr_fifo_data),
    .port_wr_re(port_wr_re), .port_wr_done(port_wr_done), .port_req_ovf(port_req_ovf),
    .busy(busy), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  // clock / cycle counter
  always #5 sys_clk = ~sys_clk;
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // model state
  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0]        fifo_q [NUM_PORTS][$];
  logic [ADDR_W+DATA_W-1:0] exp_q  [NUM_PORTS][$];
  int                       len_q  [NUM_PORTS][$];
  logic [NUM_PORTS-1:0]     model_pend = '0;
  logic [NUM_PORTS-1:0]     model_ovf  = '0;
  int                       model_rr = 0;
  int                       outstanding = 0;
  logic [ADDR_W-1:0]        req_addr [NUM_PORTS];
  logic [LEN_W-1:0]         req_len  [NUM_PORTS];
  logic [ADDR_W-1:0]        wr_log[$];
  int                       grant_log[$];
  int act = -1, act_len = 0, ren_cnt = 0, ren_total = 0, last_ren_cyc = 0;
  int we_len = 0, we_starts = 0, done_cnt = 0;
  int req_cyc = 0, grant_cyc = 0, first_ren_cyc = 0;
  logic prev_we_n = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_grant();
    for (int k = 0; k < NUM_PORTS; k++) begin
      int p = (model_rr + k) % NUM_PORTS;
      if (model_pend[p]) return p;
    end
    return -1;
  endfunction

  function automatic logic [NUM_PORTS-1:0] act_mask();
    return (act >= 0) ? (NUM_PORTS'(1) << act) : '0;
  endfunction

  task automatic check_reset_outputs();
    check("rst_cs_n", sram_cs_n, 1);
    check("rst_we_n", sram_we_n, 1);
    check("rst_oe_n", sram_oe_n, 1);
    check("rst_addr", sram_addr, 0);
    check("rst_wdata", sram_wdata, 0);
    check("rst_ren", wr_fifo_ren, 0);
    check("rst_wr_re", port_wr_re, 0);
    check("rst_done", port_wr_done, 0);
    check("rst_ovf", port_req_ovf, 0);
    check("rst_busy", busy, 0);
  endtask

  task automatic flush_model();
    model_pend = '0; model_ovf = '0; model_rr = 0; outstanding = 0;
    act = -1; prev_we_n = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      fifo_q[i].delete(); exp_q[i].delete(); len_q[i].delete();
    end
  endtask

  // driver: strobe the masked ports, then book the request in the model after the sampling edge
  task automatic issue(input logic [NUM_PORTS-1:0] mask);
    @(posedge sys_clk); #1;
    for (int i = 0; i < NUM_PORTS; i++)
      if (mask[i]) port_que_info[i*QW +: QW] = {req_len[i], req_addr[i]};
    port_req_done = mask;
    req_cyc = cyc + 1;
    @(posedge sys_clk); #1;
    port_req_done = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (mask[i]) begin
        if (model_pend[i]) model_ovf[i] = 1'b1;
        else begin
          model_pend[i] = 1'b1;
          outstanding++;
          len_q[i].push_back(int'(req_len[i]));
          for (int k = 0; k < int'(req_len[i]); k++) begin
            logic [DATA_W-1:0] d;
            d = DATA_W'($urandom);
            fifo_q[i].push_back(d);
            exp_q[i].push_back({ADDR_W'(int'(req_addr[i]) + k), d});
          end
        end
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((outstanding != 0 || busy) && n < budget) begin
      @(posedge sys_clk); #1;
      n++;
    end
    check("idle_reached", (outstanding == 0 && !busy), 1);
  endtask

  // monitor / scoreboard, sampled on the falling edge
  task automatic monitor();
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n) begin
        if (port_wr_re != '0) begin
          int g;
          g = 0;
          for (int i = 0; i < NUM_PORTS; i++) if (port_wr_re[i]) g = i;
          check("re_onehot", $countones(port_wr_re), 1);
          check("cs_idle_at_grant", sram_cs_n, 1);
          check("grant_port", g, exp_grant());
          act = g; model_pend[g] = 1'b0; model_rr = (g + 1) % NUM_PORTS;
          grant_log.push_back(g); grant_cyc = cyc; ren_cnt = 0;
          if (len_q[g].size() > 0) act_len = len_q[g].pop_front();
          else begin act_len = -1; check("grant_unrequested", 1, 0); end
        end
        if (wr_fifo_ren != '0) begin
          check("ren_port", wr_fifo_ren, act_mask());
          if (act >= 0) begin
            if (ren_cnt == 0) first_ren_cyc = cyc;
            else check("word_cycles", cyc - last_ren_cyc, 3 + WE_CYC);
            last_ren_cyc = cyc; ren_cnt++; ren_total++;
            if (fifo_q[act].size() > 0) wr_fifo_data[act*DATA_W +: DATA_W] = fifo_q[act].pop_front();
          end
        end
        if (!sram_we_n) begin
          if (prev_we_n) begin
            logic [ADDR_W+DATA_W-1:0] e;
            we_len = 1; we_starts++;
            wr_log.push_back(sram_addr);
            check("cs_low_in_we", sram_cs_n, 0);
            if (act >= 0 && exp_q[act].size() > 0) begin
              e = exp_q[act].pop_front();
              check("wr_addr", sram_addr, e[DATA_W +: ADDR_W]);
              check("wr_data", sram_wdata, e[DATA_W-1:0]);
            end else check("unexpected_write", 1, 0);
          end else we_len++;
        end else if (!prev_we_n) check("we_width", we_len, WE_CYC);
        prev_we_n = sram_we_n;
        if (port_wr_done != '0) begin
          check("done_port", port_wr_done, act_mask());
          check("ren_count", ren_cnt, act_len);
          check("cs_high_at_done", sram_cs_n, 1);
          done_cnt++; outstanding--; act = -1;
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
      begin
        int d0, r0, n;
        logic [NUM_PORTS-1:0] mask;
        // reset state
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1 check_reset_outputs();
        sys_rst_n = 1'b1;

        // ports 0 and 2 together twice: order 0,2 then (ptr at 3) 0,2
        grant_log.delete();
        req_addr[0] = 15'h0100; req_len[0] = 11'd2;
        req_addr[2] = 15'h0200; req_len[2] = 11'd1;
        issue(4'b0101); wait_idle(300);
        issue(4'b0101); wait_idle(300);
        check("rr_cnt", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
          check("rr_g0", grant_log[0], 0); check("rr_g1", grant_log[1], 2);
          check("rr_g2", grant_log[2], 0); check("rr_g3", grant_log[3], 2);
        end

        // port0 at 0x0421, 4 words, with request-to-grant-to-ren latency
        wr_log.delete(); d0 = done_cnt;
        req_addr[0] = 15'h0421; req_len[0] = 11'd4;
        issue(4'b0001); wait_idle(300);
        check("lat_grant", grant_cyc - req_cyc, 0);
        check("lat_ren", first_ren_cyc - req_cyc, 1);
        check("t1_words", wr_log.size(), 4);
        for (int k = 0; k < wr_log.size(); k++) check("t1_addr", wr_log[k], 32'h421 + k);
        check("t1_done", done_cnt - d0, 1);

        // port1 wrapping past the top address
        wr_log.delete();
        req_addr[1] = 15'h7FFE; req_len[1] = 11'd3;
        issue(4'b0010); wait_idle(300);
        check("t2_words", wr_log.size(), 3);
        if (wr_log.size() == 3) begin
          check("t2_a0", wr_log[0], 32'h7FFE); check("t2_a1", wr_log[1], 32'h7FFF);
          check("t2_a2", wr_log[2], 32'h0000);
        end

        // port3 zero length
        d0 = done_cnt; r0 = ren_total; wr_log.delete();
        req_addr[3] = 15'h1234; req_len[3] = 11'd0;
        issue(4'b1000); wait_idle(100);
        check("t4_done", done_cnt - d0, 1);
        check("t4_no_ren", ren_total - r0, 0);
        check("t4_no_write", wr_log.size(), 0);

        // overflow on port0 while its slot is full
        d0 = done_cnt;
        req_addr[1] = 15'h0500; req_len[1] = 11'd3; issue(4'b0010);
        req_addr[0] = 15'h0600; req_len[0] = 11'd2; issue(4'b0001);
        req_len[0] = 11'd5; issue(4'b0001);
        check("ovf_set", port_req_ovf, 4'b0001);
        issue(4'b0001);
        wait_idle(500);
        check("ovf_sticky", port_req_ovf, 4'b0001);
        check("ovf_model", port_req_ovf, model_ovf);
        check("ovf_dones", done_cnt - d0, 2);

        // random traffic
        repeat (60) begin
          mask = '0;
          for (int i = 0; i < NUM_PORTS; i++) begin
            if (!model_pend[i] && $urandom_range(0, 2) == 0) begin
              mask[i] = 1'b1;
              req_addr[i] = ($urandom_range(0, 3) == 0) ? 15'h7FFD + 15'($urandom_range(0, 2))
                                                        : ADDR_W'($urandom);
              req_len[i] = LEN_W'($urandom_range(0, 5));
            end
          end
          if (mask != '0) issue(mask);
          else @(posedge sys_clk);
          repeat ($urandom_range(0, 8)) @(posedge sys_clk);
        end
        wait_idle(5000);
        check("rand_ovf", port_req_ovf, model_ovf);

        // reset during WE of the second word
        we_starts = 0; d0 = done_cnt;
        req_addr[2] = 15'h0700; req_len[2] = 11'd4;
        issue(4'b0100);
        n = 0;
        while (we_starts < 2 && n < 200) begin @(posedge sys_clk); #2; n++; end
        check("we2_reached", (we_starts >= 2), 1);
        check("we_low_before_rst", sram_we_n, 0);
        sys_rst_n = 1'b0;
        #1 check_reset_outputs();
        flush_model();
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        repeat (3) @(posedge sys_clk);
        check("no_done_after_rst", done_cnt - d0, 0);
        req_addr[2] = 15'h0010; req_len[2] = 11'd2;
        issue(4'b0100); wait_idle(300);
        check("post_rst_done", done_cnt - d0, 1);
        check("post_rst_ovf", port_req_ovf, 0);
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
